// File: rtl/i2c_shift_engine.sv
// Serial byte/word shift engine for the I2C datapath: one TX or RX transfer per start, optional ACK slot.
// Optional abort input is enabled by defining I2C_SHIFT_ABORT_EN.
module i2c_shift_engine #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit ACK_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              bit_tick,
`ifdef I2C_SHIFT_ABORT_EN
    input  logic              abort,
`endif
    input  logic              sda_in,
    input  logic              nack_in,
    output logic              sda_out,
    output logic              sda_oe,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              nack_rcvd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state, state_n;
    logic              dir_q, dir_n;
    logic [DATA_W-1:0] shifter, shifter_n;
    logic [DATA_W-1:0] rx_n;
    logic [CNT_W-1:0]  bit_cnt, cnt_n;
    logic              nack_q, nack_q_n;
    logic              nack_rcvd_n;
    logic              out_n, oe_n;
    logic              abort_hit;

`ifdef I2C_SHIFT_ABORT_EN
    assign abort_hit = abort && ((state == S_SHIFT) || (state == S_ACK));
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        dir_n       = dir_q;
        shifter_n   = shifter;
        cnt_n       = bit_cnt;
        nack_q_n    = nack_q;
        nack_rcvd_n = nack_rcvd;
        rx_n        = rx_data;

        if (abort_hit) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n   = S_SHIFT;
                        dir_n     = dir;
                        shifter_n = dir ? '0 : tx_data;
                        cnt_n     = CNT_W'(DATA_W);
                    end
                end
                S_SHIFT: begin
                    if (bit_tick) begin
                        if (dir_q) begin
                            shifter_n = MSB_FIRST ? {shifter[DATA_W-2:0], sda_in}
                                                  : {sda_in, shifter[DATA_W-1:1]};
                        end else begin
                            shifter_n = MSB_FIRST ? {shifter[DATA_W-2:0], 1'b0}
                                                  : {1'b0, shifter[DATA_W-1:1]};
                        end
                        cnt_n = bit_cnt - CNT_W'(1);
                        if (bit_cnt == CNT_W'(1)) begin
                            if (ACK_EN) begin
                                state_n  = S_ACK;
                                nack_q_n = nack_in;
                            end else begin
                                state_n = S_DONE;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (bit_tick) begin
                        if (!dir_q) begin
                            nack_rcvd_n = sda_in;
                        end
                        state_n = S_DONE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        // Captured from the next-cycle shifter so the last RX bit lands even without an ACK slot.
        if ((state_n == S_DONE) && (state != S_DONE) && dir_q) begin
            rx_n = shifter_n;
        end

        // Pad outputs are registered from next-state values so they are valid on the first cycle of each state.
        oe_n  = ((state_n == S_SHIFT) && !dir_n) || ((state_n == S_ACK) && dir_n);
        out_n = 1'b1;
        if ((state_n == S_SHIFT) && !dir_n) begin
            out_n = MSB_FIRST ? shifter_n[DATA_W-1] : shifter_n[0];
        end else if ((state_n == S_ACK) && dir_n) begin
            out_n = nack_q_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dir_q     <= 1'b0;
            shifter   <= '0;
            bit_cnt   <= '0;
            nack_q    <= 1'b0;
            nack_rcvd <= 1'b0;
            rx_data   <= '0;
            sda_out   <= 1'b1;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            dir_q     <= dir_n;
            shifter   <= shifter_n;
            bit_cnt   <= cnt_n;
            nack_q    <= nack_q_n;
            nack_rcvd <= nack_rcvd_n;
            rx_data   <= rx_n;
            sda_out   <= out_n;
            sda_oe    <= oe_n;
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
        end
    end

endmodule
